mvm_output_requant: RTL and testbench
=====================================

# mvm_output_requant

- **Placement:** AXI-Stream stage directly downstream of the two-stage MVM pipeline.
- **Function:** consumes beats of 32-bit signed accumulator lanes, requantizes each lane to 8-bit signed (rounding arithmetic right shift, then saturation), and packs `PACK` consecutive input beats into one full-width output beat.
- **Purpose:** returns results in the same 8-bit format the first MVM stage consumes, so results can be written back or chained to the next layer.

## Interface
Parameters:
- `DATAW`, 512: TDATA width, both sides.
- `IDW`, 32: TID width.
- `USERW`, 75: TUSER width.
- `DESTW`, 4: TDEST width.
- `IPRECISION`, 32: input lane width.
- `OPRECISION`, 8: output lane width.
- Derived `ELANES` = `DATAW`/`IPRECISION` (16); derived `PACK` = `IPRECISION`/`OPRECISION` (4).

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_shift`  in  5  right-shift amount; must be held stable while any group is in flight.
- `axis_rx_tvalid`, `axis_rx_tready`, `axis_rx_tdata`, `axis_rx_tlast`, `axis_rx_tid`, `axis_rx_tuser`, `axis_rx_tdest`  in/out  1/1/`DATAW`/1/`IDW`/`USERW`/`DESTW`  slave stream from the MVM.
- `axis_tx_tvalid`, `axis_tx_tready`, `axis_tx_tdata`, `axis_tx_tlast`, `axis_tx_tid`, `axis_tx_tuser`, `axis_tx_tdest`  out/in  same widths  master stream.
- `sat_count`  out  16  saturating count of lanes clipped since reset.

## Operation
**Per-lane requantization** (lane i = `tdata[32i+31:32i]`, signed):
- Compute in 33-bit signed: r = (x + R) >>> `cfg_shift`, where R = 0 if shift = 0, else 1 << (shift−1). This is round-half-up toward +inf.
- Saturate r to [−128, 127].
- Each clipped lane adds 1 to `sat_count`; the counter sticks at 0xFFFF.

**Packing:**
- 2-bit slot counter `slot` (0..PACK−1).
- Requantized lane i of an accepted beat is written to accumulation-register byte `slot*ELANES + i`.
- A group completes on an accepted beat with `slot` = PACK−1 or `tlast` = 1.
- On completion, the accumulator plus the current beat's bytes load the output register, and the accumulator and `slot` clear to 0.
- Otherwise, `slot` increments.
- Partial groups (tlast before slot 3) zero the unfilled bytes.

**Sideband:**
- Output `tid`/`tuser`/`tdest` come from the completing input beat.
- Output `tlast` = input `tlast` of the completing beat.

**Flow control:**
- `axis_rx_tready` = !`rst` && (!`axis_tx_tvalid` || `axis_tx_tready`).
- This value is independent of `axis_rx_tvalid` and `slot`.

**Output register:**
- `axis_tx_tvalid` sets on completion.
- It clears on (`tx_tvalid` && `tx_tready`) when no new completion occurs in the same cycle.
- Payload is held stable while `tvalid` && !`tready`.

## Timing
- **Reset values:**
  - `axis_tx_tvalid`, `tdata`, `tlast`, `tid`, `tuser`, `tdest` = 0.
  - `sat_count` = 0; `slot` = 0; accumulator = 0.
  - `axis_rx_tready` = 0 while `rst` is high, 1 on the first cycle after.
- **Latency:** `axis_tx_tvalid` rises the cycle after the completing input handshake.
- **Throughput:** one input beat per cycle; one output beat per `PACK` inputs.
- **Simultaneous output handshake and completion:** new beat loads the register and `tvalid` stays 1 (back-to-back output).
- **Back-pressure:** `tx_tready` low with `tx_tvalid` high stalls input entirely, including mid-group slots. The accumulator holds its contents.
- **Reset mid-group or mid-stall:** partial accumulator and pending output are discarded. No beat emerges after reset until a fresh group completes.
- **`sat_count` timing:** updates in the cycle of the input handshake; no change when no handshake occurs.

## Test plan
- **Rounding:** shift = 4; four beats with all lanes = 0x00000018 (24) → one output beat with all 64 bytes = 0x02 ((24+8)>>4 = 2), `tlast` follows beat 4; `sat_count` = 0.
- **Saturation:** shift = 0; lanes alternate 300 and −300; four beats → bytes alternate 0x7F / 0x80; `sat_count` = 64.
- **Negative rounding:** shift = 1, lane = −3 → (−3+1)>>>1 = −1 = 0xFF; lane = −4 → −2 = 0xFE.
- **Early tlast:** beat 0 (tlast = 0), beat 1 (tlast = 1), all lanes 0x10, shift = 0:
  - Output bytes 0..31 = 0x10, bytes 32..63 = 0x00, `tlast` = 1.
  - Next group starts at slot 0.
- **Back-pressure:** hold `tx_tready` = 0 for 10 cycles with an output pending:
  - `rx_tready` stays 0; payload stays stable.
  - On release, the beat is transferred and the next group completes without loss or reordering across 8 groups of random data.
- **Reset mid-group:** assert `rst` after 2 beats, deassert, send 4 beats:
  - Exactly one output appears, containing only the post-reset data.
  - `sat_count` restarts at 0.

Source files
------------

// File: rtl/mvm_output_requant.sv
// rtl/mvm_output_requant.sv - requantize 32-bit accumulator lanes to 8-bit and pack PACK beats per output
module mvm_output_requant #(
  parameter int DATAW      = 512,
  parameter int IDW        = 32,
  parameter int USERW      = 75,
  parameter int DESTW      = 4,
  parameter int IPRECISION = 32,
  parameter int OPRECISION = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       cfg_shift,
  input  logic             axis_rx_tvalid,
  output logic             axis_rx_tready,
  input  logic [DATAW-1:0] axis_rx_tdata,
  input  logic             axis_rx_tlast,
  input  logic [IDW-1:0]   axis_rx_tid,
  input  logic [USERW-1:0] axis_rx_tuser,
  input  logic [DESTW-1:0] axis_rx_tdest,
  output logic             axis_tx_tvalid,
  input  logic             axis_tx_tready,
  output logic [DATAW-1:0] axis_tx_tdata,
  output logic             axis_tx_tlast,
  output logic [IDW-1:0]   axis_tx_tid,
  output logic [USERW-1:0] axis_tx_tuser,
  output logic [DESTW-1:0] axis_tx_tdest,
  output logic [15:0]      sat_count
);
  localparam int ELANES = DATAW / IPRECISION;
  localparam int PACK   = IPRECISION / OPRECISION;
  localparam int SLOTW  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CHUNKW = ELANES * OPRECISION;
  localparam int SUMW   = IPRECISION + 1;
  localparam int CLIPW  = $clog2(ELANES + 1);
  localparam logic signed [SUMW-1:0] QMAX = SUMW'(2 ** (OPRECISION - 1) - 1);
  localparam logic signed [SUMW-1:0] QMIN = ~QMAX;

  logic [SLOTW-1:0]        r_slot;
  logic [DATAW-1:0]        r_acc;
  logic                    r_tvalid;
  logic [DATAW-1:0]        r_tdata;
  logic                    r_tlast;
  logic [IDW-1:0]          r_tid;
  logic [USERW-1:0]        r_tuser;
  logic [DESTW-1:0]        r_tdest;
  logic [15:0]             r_sat;

  logic                    w_rx_ready;
  logic                    w_rx_fire;
  logic                    w_complete;
  logic signed [SUMW-1:0]  w_round;
  logic signed [SUMW-1:0]  w_sum [ELANES];
  logic signed [SUMW-1:0]  w_shr [ELANES];
  logic [CHUNKW-1:0]       w_chunk;
  logic [CLIPW-1:0]        w_nclip;
  logic [DATAW-1:0]        w_merged;
  logic [16:0]             w_sat_sum;
  logic [15:0]             w_sat_next;

  // Input stalls whenever the single output register cannot be freed this cycle.
  assign w_rx_ready = !rst && (!r_tvalid || axis_tx_tready);
  assign w_rx_fire  = axis_rx_tvalid && w_rx_ready;
  assign w_complete = axis_rx_tlast || (r_slot == SLOTW'(PACK - 1));

  always_comb begin
    w_round = '0;
    if (cfg_shift != 5'd0) w_round = SUMW'(1) << (cfg_shift - 5'd1);
    w_nclip = '0;
    w_chunk = '0;
    for (int i = 0; i < ELANES; i++) begin
      w_sum[i] = {axis_rx_tdata[i*IPRECISION+IPRECISION-1], axis_rx_tdata[i*IPRECISION +: IPRECISION]} + w_round;
      w_shr[i] = w_sum[i] >>> cfg_shift;
      if (w_shr[i] > QMAX) begin
        w_chunk[i*OPRECISION +: OPRECISION] = QMAX[OPRECISION-1:0];
        w_nclip = w_nclip + CLIPW'(1);
      end else if (w_shr[i] < QMIN) begin
        w_chunk[i*OPRECISION +: OPRECISION] = QMIN[OPRECISION-1:0];
        w_nclip = w_nclip + CLIPW'(1);
      end else begin
        w_chunk[i*OPRECISION +: OPRECISION] = w_shr[i][OPRECISION-1:0];
      end
    end
  end

  // Slots above the current one are still zero in the accumulator, so a short group pads itself.
  always_comb begin
    w_merged = '0;
    for (int s = 0; s < PACK; s++) begin
      w_merged[s*CHUNKW +: CHUNKW] = (r_slot == SLOTW'(s)) ? w_chunk : r_acc[s*CHUNKW +: CHUNKW];
    end
  end

  assign w_sat_sum  = {1'b0, r_sat} + 17'(w_nclip);
  assign w_sat_next = w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot   <= '0;
      r_acc    <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tid    <= '0;
      r_tuser  <= '0;
      r_tdest  <= '0;
      r_sat    <= '0;
    end else begin
      if (r_tvalid && axis_tx_tready) r_tvalid <= 1'b0;
      if (w_rx_fire) begin
        r_sat <= w_sat_next;
        if (w_complete) begin
          r_tvalid <= 1'b1;
          r_tdata  <= w_merged;
          r_tlast  <= axis_rx_tlast;
          r_tid    <= axis_rx_tid;
          r_tuser  <= axis_rx_tuser;
          r_tdest  <= axis_rx_tdest;
          r_acc    <= '0;
          r_slot   <= '0;
        end else begin
          r_acc    <= w_merged;
          r_slot   <= r_slot + SLOTW'(1);
        end
      end
    end
  end

  assign axis_rx_tready = w_rx_ready;
  assign axis_tx_tvalid = r_tvalid;
  assign axis_tx_tdata  = r_tdata;
  assign axis_tx_tlast  = r_tlast;
  assign axis_tx_tid    = r_tid;
  assign axis_tx_tuser  = r_tuser;
  assign axis_tx_tdest  = r_tdest;
  assign sat_count      = r_sat;
endmodule

// File: tb/tb_mvm_output_requant.sv
// tb/tb_mvm_output_requant.sv - randomized and directed bench for mvm_output_requant
module tb_mvm_output_requant;
  localparam int DATAW = 512;
  localparam int IDW   = 32;
  localparam int USERW = 75;
  localparam int DESTW = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       cfg_shift;
  logic             axis_rx_tvalid;
  logic             axis_rx_tready;
  logic [DATAW-1:0] axis_rx_tdata;
  logic             axis_rx_tlast;
  logic [IDW-1:0]   axis_rx_tid;
  logic [USERW-1:0] axis_rx_tuser;
  logic [DESTW-1:0] axis_rx_tdest;
  logic             axis_tx_tvalid;
  logic             axis_tx_tready;
  logic [DATAW-1:0] axis_tx_tdata;
  logic             axis_tx_tlast;
  logic [IDW-1:0]   axis_tx_tid;
  logic [USERW-1:0] axis_tx_tuser;
  logic [DESTW-1:0] axis_tx_tdest;
  logic [15:0]      sat_count;

  mvm_output_requant dut (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift),
    .axis_rx_tvalid(axis_rx_tvalid), .axis_rx_tready(axis_rx_tready),
    .axis_rx_tdata(axis_rx_tdata), .axis_rx_tlast(axis_rx_tlast),
    .axis_rx_tid(axis_rx_tid), .axis_rx_tuser(axis_rx_tuser), .axis_rx_tdest(axis_rx_tdest),
    .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready),
    .axis_tx_tdata(axis_tx_tdata), .axis_tx_tlast(axis_tx_tlast),
    .axis_tx_tid(axis_tx_tid), .axis_tx_tuser(axis_tx_tuser), .axis_tx_tdest(axis_tx_tdest),
    .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [DATAW-1:0] got, input logic [DATAW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DATAW-1:0] d;
    logic             l;
    logic [IDW-1:0]   id;
    logic [USERW-1:0] u;
    logic [DESTW-1:0] de;
  } beat_t;

  beat_t            expq[$];
  logic [DATAW-1:0] m_grp;
  int               m_slot;
  int               exp_sat;

  function automatic logic [7:0] rq(input int x, input int sh, output bit clip);
    longint v;
    v = longint'(x);
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    clip = 1'b0;
    if (v > 127) begin clip = 1'b1; return 8'h7F; end
    if (v < -128) begin clip = 1'b1; return 8'h80; end
    return v[7:0];
  endfunction

  task automatic model_beat(input beat_t b);
    bit    c;
    beat_t e;
    for (int i = 0; i < 16; i++) begin
      m_grp[(m_slot*16+i)*8 +: 8] = rq($signed(b.d[i*32 +: 32]), int'(cfg_shift), c);
      if (c && exp_sat < 65535) exp_sat++;
    end
    if (m_slot == 3 || b.l) begin
      e = b;
      e.d = m_grp;
      expq.push_back(e);
      m_grp = '0;
      m_slot = 0;
    end else begin
      m_slot++;
    end
  endtask

  // Output monitor: handshakes are seen on the negedge before the edge that completes them.
  int               n_out = 0;
  logic [DATAW-1:0] last_d;
  logic             last_l;
  logic             pv = 1'b0;
  logic             pr = 1'b0;
  logic [DATAW-1:0] pd;
  beat_t            mon_e;

  always @(negedge clk) begin
    if (!rst && pv && !pr) begin
      check("hold_valid", DATAW'(axis_tx_tvalid), DATAW'(1));
      check("hold_data", axis_tx_tdata, pd);
    end
    if (!rst && axis_tx_tvalid && axis_tx_tready) begin
      n_out++;
      last_d = axis_tx_tdata;
      last_l = axis_tx_tlast;
      if (expq.size() == 0) begin
        check("unexpected_out", DATAW'(1), DATAW'(0));
      end else begin
        mon_e = expq.pop_front();
        check("out_data", axis_tx_tdata, mon_e.d);
        check("out_last", DATAW'(axis_tx_tlast), DATAW'(mon_e.l));
        check("out_tid", DATAW'(axis_tx_tid), DATAW'(mon_e.id));
        check("out_tuser", DATAW'(axis_tx_tuser), DATAW'(mon_e.u));
        check("out_tdest", DATAW'(axis_tx_tdest), DATAW'(mon_e.de));
      end
    end
    pv = axis_tx_tvalid && !rst;
    pr = axis_tx_tready;
    pd = axis_tx_tdata;
  end

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       axis_tx_tready = 1'b1;
      1:       axis_tx_tready = 1'($urandom_range(0, 1));
      default: axis_tx_tready = 1'b0;
    endcase
  end

  function automatic logic [DATAW-1:0] mk(input int a, input int b);
    logic [DATAW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = (i % 2 == 0) ? a : b;
    return r;
  endfunction

  function automatic logic [DATAW-1:0] rnd_beat();
    logic [DATAW-1:0] r;
    int v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      v = v >>> $urandom_range(0, 28);
      r[i*32 +: 32] = v;
    end
    return r;
  endfunction

  task automatic send(input logic [DATAW-1:0] d, input bit l);
    beat_t b;
    int    n;
    b.d  = d;
    b.l  = l;
    b.id = $urandom;
    b.u  = USERW'({$urandom, $urandom, $urandom});
    b.de = DESTW'($urandom);
    axis_rx_tdata  = b.d;
    axis_rx_tlast  = b.l;
    axis_rx_tid    = b.id;
    axis_rx_tuser  = b.u;
    axis_rx_tdest  = b.de;
    axis_rx_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axis_rx_tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (axis_rx_tready) model_beat(b);
    else check("rx_timeout", DATAW'(0), DATAW'(1));
    @(posedge clk);
    #1;
    axis_rx_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || axis_tx_tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", DATAW'(0), DATAW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    axis_rx_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_tready", DATAW'(axis_rx_tready), DATAW'(0));
    check("rst_tx_tvalid", DATAW'(axis_tx_tvalid), DATAW'(0));
    check("rst_tx_tdata", axis_tx_tdata, DATAW'(0));
    check("rst_tx_tlast", DATAW'(axis_tx_tlast), DATAW'(0));
    check("rst_sat_count", DATAW'(sat_count), DATAW'(0));
    expq.delete();
    m_grp = '0;
    m_slot = 0;
    exp_sat = 0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rx_tready", DATAW'(axis_rx_tready), DATAW'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int n0;
  int groups;
  int s;
  bit l;

  initial begin
    rst = 1'b1;
    cfg_shift = '0;
    axis_rx_tvalid = 1'b0;
    axis_rx_tdata = '0;
    axis_rx_tlast = 1'b0;
    axis_rx_tid = '0;
    axis_rx_tuser = '0;
    axis_rx_tdest = '0;
    axis_tx_tready = 1'b0;
    m_grp = '0;
    m_slot = 0;
    exp_sat = 0;
    do_reset();

    cfg_shift = 5'd4;
    n0 = n_out;
    for (int b = 0; b < 4; b++) send(mk(24, 24), b == 3);
    drain();
    check("round_data", last_d, {64{8'h02}});
    check("round_last", DATAW'(last_l), DATAW'(1));
    check("round_nout", DATAW'(n_out - n0), DATAW'(1));
    check("round_sat", DATAW'(sat_count), DATAW'(0));

    cfg_shift = 5'd0;
    for (int b = 0; b < 4; b++) send(mk(300, -300), 1'b0);
    drain();
    check("sat_data", last_d, {32{8'h80, 8'h7F}});
    check("sat_last", DATAW'(last_l), DATAW'(0));
    check("sat_count64", DATAW'(sat_count), DATAW'(64));

    cfg_shift = 5'd1;
    for (int b = 0; b < 4; b++) send(mk(-3, -4), 1'b0);
    drain();
    check("negrnd_data", last_d, {32{8'hFE, 8'hFF}});

    cfg_shift = 5'd0;
    send(mk(16, 16), 1'b0);
    send(mk(16, 16), 1'b1);
    drain();
    check("early_data", last_d, {{32{8'h00}}, {32{8'h10}}});
    check("early_last", DATAW'(last_l), DATAW'(1));
    for (int b = 0; b < 4; b++) send(mk(1, 1), 1'b0);
    drain();
    check("after_early_data", last_d, {64{8'h01}});
    check("sat_model", DATAW'(sat_count), DATAW'(exp_sat));

    rdy_mode = 2;
    cfg_shift = 5'($urandom_range(0, 12));
    for (int b = 0; b < 4; b++) send(rnd_beat(), 1'b0);
    check("bp_pending", DATAW'(axis_tx_tvalid), DATAW'(1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_rx_tready", DATAW'(axis_rx_tready), DATAW'(0));
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    groups = 0;
    s = 0;
    while (groups < 8) begin
      l = ($urandom_range(0, 4) == 0);
      send(rnd_beat(), l);
      if (s == 3 || l) begin groups++; s = 0; end
      else s++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    check("rand_queue_empty", DATAW'(expq.size()), DATAW'(0));
    check("rand_sat", DATAW'(sat_count), DATAW'(exp_sat));
    rdy_mode = 0;

    cfg_shift = 5'd0;
    send(mk(1000, -1000), 1'b0);
    send(mk(1000, -1000), 1'b0);
    do_reset();
    n0 = n_out;
    for (int b = 0; b < 4; b++) send(mk(5, 5), 1'b0);
    drain();
    repeat (20) @(negedge clk);
    check("rstmid_nout", DATAW'(n_out - n0), DATAW'(1));
    check("rstmid_data", last_d, {64{8'h05}});
    check("rstmid_sat", DATAW'(sat_count), DATAW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
